// File: rtl/reorder_buffer_n_pkg.sv
// Shared definitions for the reorder buffer: default sizing and the per-entry field layout.
// ROB_HEAD_BYPASS_EN (see reorder_buffer_n.sv) selects the same-cycle head completion path.
package reorder_buffer_n_pkg;

  localparam int ROB_DEPTH_W_DEF = 4;
  localparam int NUM_WB_DEF      = 2;
  localparam int XLEN_DEF        = 32;
  localparam int RD_W            = 5;

  // Control part of an entry; val and pc are held alongside, sized by XLEN.
  typedef struct packed {
    logic            busy;
    logic            done;
    logic [RD_W-1:0] rd_idx;
  } rob_meta_t;

  localparam rob_meta_t META_EMPTY = '{busy: 1'b0, done: 1'b0, rd_idx: 5'd0};

  function automatic rob_meta_t meta_alloc(input logic [RD_W-1:0] rd_idx);
    rob_meta_t m;
    m.busy   = 1'b1;
    m.done   = 1'b0;
    m.rd_idx = rd_idx;
    return m;
  endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Writeback port merge: turns NUM_WB tagged results into one write enable and value per slot.
// When several ports carry the same tag, the lowest-numbered port supplies the value.
module rob_wb_merge #(
  parameter int DEPTH_W = 4,
  parameter int NUM_WB  = 2,
  parameter int XLEN    = 32,
  localparam int DEPTH  = 1 << DEPTH_W
) (
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*DEPTH_W-1:0]  wb_tag,
  input  logic [NUM_WB*XLEN-1:0]     wb_val,
  output logic [DEPTH-1:0]           slot_we,
  output logic [DEPTH-1:0][XLEN-1:0] slot_val
);

  // Per-slot priority select, first matching port in ascending order wins
  always_comb begin
    slot_we  = '0;
    slot_val = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int p = 0; p < NUM_WB; p++) begin
        slot_val[s] = (wb_valid[p] && (wb_tag[p*DEPTH_W +: DEPTH_W] == DEPTH_W'(s)) && !slot_we[s])
                      ? wb_val[p*XLEN +: XLEN] : slot_val[s];
        slot_we[s]  = slot_we[s] | (wb_valid[p] && (wb_tag[p*DEPTH_W +: DEPTH_W] == DEPTH_W'(s)));
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_n.sv
// Circular reorder buffer: in-order dispatch, tag-indexed out-of-order writeback, in-order commit.
// Define ROB_HEAD_BYPASS_EN to let a writeback to the head entry commit in the same cycle.
module reorder_buffer_n
  import reorder_buffer_n_pkg::*;
#(
  parameter int ROB_DEPTH_W = ROB_DEPTH_W_DEF,
  parameter int NUM_WB      = NUM_WB_DEF,
  parameter int XLEN        = XLEN_DEF,
  localparam int TAG_W      = ROB_DEPTH_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    push_valid,
  input  logic [RD_W-1:0]         push_rd_idx,
  input  logic [XLEN-1:0]         push_pc,
  output logic                    push_ready,
  output logic [TAG_W-1:0]        push_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]  wb_val,
  input  logic                    flush,
  output logic                    commit_valid,
  input  logic                    commit_ready,
  output logic [TAG_W-1:0]        commit_tag,
  output logic [RD_W-1:0]         commit_rd_idx,
  output logic [XLEN-1:0]         commit_val,
  output logic [XLEN-1:0]         commit_pc,
  output logic [ROB_DEPTH_W:0]    rob_count
);

  localparam int DEPTH = 1 << ROB_DEPTH_W;
  localparam logic [ROB_DEPTH_W:0] FULL = {1'b1, {ROB_DEPTH_W{1'b0}}};

  rob_meta_t             meta  [DEPTH];
  logic [XLEN-1:0]       val_q [DEPTH];
  logic [XLEN-1:0]       pc_q  [DEPTH];
  logic [TAG_W-1:0]      head;
  logic [TAG_W-1:0]      tail;
  logic [DEPTH-1:0]      slot_we;
  logic [DEPTH-1:0][XLEN-1:0] slot_val;
  logic                  head_done;
  logic                  do_push;
  logic                  do_pop;

  rob_wb_merge #(
    .DEPTH_W (ROB_DEPTH_W),
    .NUM_WB  (NUM_WB),
    .XLEN    (XLEN)
  ) u_wb_merge (
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_val   (wb_val),
    .slot_we  (slot_we),
    .slot_val (slot_val)
  );

  // Head view, handshakes and push/pop decisions
  always_comb begin
    head_done  = meta[head].done;
    commit_val = val_q[head];
`ifdef ROB_HEAD_BYPASS_EN
    if (slot_we[head] && meta[head].busy && !meta[head].done) begin
      head_done  = 1'b1;
      commit_val = slot_val[head];
    end else begin
      head_done  = meta[head].done;
      commit_val = val_q[head];
    end
`endif
    commit_valid  = (rob_count != '0) && head_done;
    commit_tag    = head;
    commit_rd_idx = meta[head].rd_idx;
    commit_pc     = pc_q[head];
    push_ready    = rdy_in && (rob_count != FULL);
    push_tag      = tail;
    do_push       = push_valid && push_ready && !flush;
    do_pop        = commit_valid && commit_ready && rdy_in && !flush;
  end

  // Entry storage and pointers; later assignments (pop, then push) take precedence per slot
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta[i]  <= META_EMPTY;
        val_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      head      <= '0;
      tail      <= '0;
      rob_count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          meta[i] <= META_EMPTY;
        end
        head      <= '0;
        tail      <= '0;
        rob_count <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (slot_we[i] && meta[i].busy && !meta[i].done) begin
            meta[i].done <= 1'b1;
            val_q[i]     <= slot_val[i];
          end
        end
        if (do_pop) begin
          meta[head]  <= META_EMPTY;
          val_q[head] <= '0;
          pc_q[head]  <= '0;
          head        <= head + 1'b1;
        end
        if (do_push) begin
          meta[tail]  <= meta_alloc(push_rd_idx);
          val_q[tail] <= '0;
          pc_q[tail]  <= push_pc;
          tail        <= tail + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   rob_count <= rob_count + 1'b1;
          2'b01:   rob_count <= rob_count - 1'b1;
          default: rob_count <= rob_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_n.sv
// Self-checking bench for reorder_buffer_n: directed scenarios plus a randomized run against
// a queue-based reference model. Honours ROB_HEAD_BYPASS_EN when defined.
module tb_reorder_buffer_n;

  localparam int W  = 4;
  localparam int NW = 2;
  localparam int XL = 32;
  localparam int D  = 16;
`ifdef ROB_HEAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           rdy_in;
  logic           push_valid;
  logic [4:0]     push_rd_idx;
  logic [XL-1:0]  push_pc;
  logic           push_ready;
  logic [W-1:0]   push_tag;
  logic [NW-1:0]  wb_valid;
  logic [NW*W-1:0]  wb_tag;
  logic [NW*XL-1:0] wb_val;
  logic           flush;
  logic           commit_valid;
  logic           commit_ready;
  logic [W-1:0]   commit_tag;
  logic [4:0]     commit_rd_idx;
  logic [XL-1:0]  commit_val;
  logic [XL-1:0]  commit_pc;
  logic [W:0]     rob_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0]  tag;
    logic [4:0]    rd;
    logic [XL-1:0] pc;
    logic          done;
    logic [XL-1:0] val;
  } ent_t;

  reorder_buffer_n #(.ROB_DEPTH_W(W), .NUM_WB(NW), .XLEN(XL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .push_valid(push_valid), .push_rd_idx(push_rd_idx), .push_pc(push_pc),
    .push_ready(push_ready), .push_tag(push_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .flush(flush), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_rd_idx(commit_rd_idx),
    .commit_val(commit_val), .commit_pc(commit_pc), .rob_count(rob_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet;
    push_valid = 1'b0; push_rd_idx = 5'd0; push_pc = 32'd0;
    wb_valid = '0; wb_tag = '0; wb_val = '0;
    flush = 1'b0; commit_ready = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic set_wb(input int p, input logic [W-1:0] t, input logic [XL-1:0] v);
    wb_valid[p] = 1'b1;
    wb_tag[p*W +: W] = t;
    wb_val[p*XL +: XL] = v;
  endtask

  task automatic push_one(input logic [4:0] rd, input logic [XL-1:0] pc);
    push_valid = 1'b1; push_rd_idx = rd; push_pc = pc;
    tick;
    push_valid = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    quiet;
    rst_in = 1'b1;
    #3;
    n_checks++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rob_count); end
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); end
    n_checks++; if (push_tag !== 4'd0) begin n_fail++; $display("FAIL reset_push_tag: got %0d expected 0", push_tag); end
    n_checks++; if ({commit_tag, commit_rd_idx, commit_val, commit_pc} !== '0) begin n_fail++; $display("FAIL reset_commit_fields: got %0h/%0h/%0h/%0h expected zeros", commit_tag, commit_rd_idx, commit_val, commit_pc); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready_hi: got %b expected 1", push_ready); end
    rdy_in = 1'b0;
    #1;
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL reset_push_ready_lo: got %b expected 0", push_ready); end
    rdy_in = 1'b1;
    tick;
    rst_in = 1'b0;
    #1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < D; i++) begin
      push_valid = 1'b1; push_rd_idx = 5'(i); push_pc = 32'h1000 + 32'(4 * i);
      #1;
      n_checks++; if (push_tag !== W'(i)) begin n_fail++; $display("FAIL fill_tag: got %0d expected %0d", push_tag, i); end
      n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b expected 1 at push %0d", push_ready, i); end
      tick;
    end
    push_valid = 1'b0;
    #1;
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", push_ready); end
    n_checks++; if (rob_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", rob_count); end
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_commit: got %b expected 0", commit_valid); end
  endtask

  task automatic test_full_pop_push;
    set_wb(0, 4'd0, 32'h55);
    tick;
    wb_valid = '0;
    commit_ready = 1'b1; push_valid = 1'b1; push_rd_idx = 5'd20; push_pc = 32'h2000;
    #1;
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready: got %b expected 0", push_ready); end
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'h55 || commit_pc !== 32'h1000) begin n_fail++; $display("FAIL fullpop_head: got v%b %0h pc %0h expected v1 55 pc 1000", commit_valid, commit_val, commit_pc); end
    tick;
    commit_ready = 1'b0; push_valid = 1'b0;
    #1;
    n_checks++; if (rob_count !== 5'd15) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 15", rob_count); end
    n_checks++; if (push_tag !== 4'd0 || push_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_next_tag: got tag %0d rdy %b expected tag 0 rdy 1", push_tag, push_ready); end
    n_checks++; if (commit_tag !== 4'd1) begin n_fail++; $display("FAIL fullpop_head_tag: got %0d expected 1", commit_tag); end
    push_one(5'd20, 32'h2000);
    #1;
    n_checks++; if (rob_count !== 5'd16 || push_tag !== 4'd1) begin n_fail++; $display("FAIL fullpop_refill: got cnt %0d tag %0d expected 16 1", rob_count, push_tag); end
  endtask

  task automatic test_flush;
    do_flush;
    for (int i = 0; i < 5; i++) push_one(5'(i), 32'h3000 + 32'(4 * i));
    set_wb(0, 4'd2, 32'h22); set_wb(1, 4'd3, 32'h33);
    tick;
    wb_valid = '0;
    n_checks++; if (rob_count !== 5'd5 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pre: got cnt %0d cv %b expected 5 0", rob_count, commit_valid); end
    flush = 1'b1; push_valid = 1'b1; commit_ready = 1'b1;
    tick;
    flush = 1'b0; push_valid = 1'b0; commit_ready = 1'b0;
    #1;
    n_checks++; if (rob_count !== 5'd0 || commit_valid !== 1'b0 || push_tag !== 4'd0 || push_ready !== 1'b1) begin n_fail++; $display("FAIL flush_post: got cnt %0d cv %b tag %0d rdy %b expected 0 0 0 1", rob_count, commit_valid, push_tag, push_ready); end
    set_wb(0, 4'd2, 32'h99);
    tick;
    wb_valid = '0;
    n_checks++; if (rob_count !== 5'd0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late_wb: got cnt %0d cv %b expected 0 0", rob_count, commit_valid); end
    for (int i = 0; i < 3; i++) push_one(5'(i + 8), 32'h3100 + 32'(4 * i));
    set_wb(0, 4'd0, 32'h0A);
    tick;
    wb_valid = '0; commit_ready = 1'b1;
    #1;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd0 || commit_val !== 32'h0A) begin n_fail++; $display("FAIL flush_reuse0: got v%b t%0d %0h expected v1 t0 a", commit_valid, commit_tag, commit_val); end
    tick;
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_done: got %b expected 0", commit_valid); end
    commit_ready = 1'b0;
    set_wb(0, 4'd1, 32'h1B); set_wb(1, 4'd2, 32'h2C);
    tick;
    wb_valid = '0; commit_ready = 1'b1;
    tick;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd2 || commit_val !== 32'h2C) begin n_fail++; $display("FAIL flush_reuse2: got v%b t%0d %0h expected v1 t2 2c", commit_valid, commit_tag, commit_val); end
    tick;
    commit_ready = 1'b0;
    n_checks++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL flush_drain: got %0d expected 0", rob_count); end
  endtask

  task automatic test_in_order;
    do_flush;
    push_one(5'd1, 32'h4000);
    push_one(5'd2, 32'h4004);
    set_wb(0, 4'd1, 32'hAA);
    tick;
    wb_valid = '0;
    set_wb(0, 4'd0, 32'h55);
    tick;
    wb_valid = '0; commit_ready = 1'b1;
    #1;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd0 || commit_val !== 32'h55 || commit_rd_idx !== 5'd1) begin n_fail++; $display("FAIL order_first: got v%b t%0d %0h rd%0d expected v1 t0 55 rd1", commit_valid, commit_tag, commit_val, commit_rd_idx); end
    tick;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_val !== 32'hAA || commit_pc !== 32'h4004) begin n_fail++; $display("FAIL order_second: got v%b t%0d %0h pc %0h expected v1 t1 aa 4004", commit_valid, commit_tag, commit_val, commit_pc); end
    tick;
    n_checks++; if (commit_valid !== 1'b0 || rob_count !== 5'd0) begin n_fail++; $display("FAIL order_empty: got v%b cnt %0d expected v0 0", commit_valid, rob_count); end
    commit_ready = 1'b0;
  endtask

  task automatic test_same_tag;
    do_flush;
    for (int i = 0; i < 4; i++) push_one(5'(i), 32'h5000 + 32'(4 * i));
    set_wb(0, 4'd3, 32'h11); set_wb(1, 4'd3, 32'h22);
    tick;
    wb_valid = '0;
    set_wb(1, 4'd3, 32'h33); set_wb(0, 4'd0, 32'h1);
    tick;
    wb_valid = '0;
    set_wb(0, 4'd1, 32'h2); set_wb(1, 4'd2, 32'h3);
    tick;
    wb_valid = '0; commit_ready = 1'b1;
    tick; tick; tick;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd3 || commit_val !== 32'h11) begin n_fail++; $display("FAIL same_tag: got v%b t%0d %0h expected v1 t3 11", commit_valid, commit_tag, commit_val); end
    tick;
    commit_ready = 1'b0;
    n_checks++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL same_tag_drain: got %0d expected 0", rob_count); end
  endtask

  task automatic test_head_bypass;
    do_flush;
    push_one(5'd7, 32'h6000);
    set_wb(0, 4'd0, 32'h7); commit_ready = 1'b1;
    #1;
`ifdef ROB_HEAD_BYPASS_EN
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'h7) begin n_fail++; $display("FAIL bypass_same_cycle: got v%b %0h expected v1 7", commit_valid, commit_val); end
    tick;
    wb_valid = '0;
    #1;
    n_checks++; if (rob_count !== 5'd0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_popped: got cnt %0d v%b expected 0 0", rob_count, commit_valid); end
`else
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %b expected 0", commit_valid); end
    tick;
    wb_valid = '0;
    #1;
    n_checks++; if (commit_valid !== 1'b1 || commit_val !== 32'h7) begin n_fail++; $display("FAIL nobypass_next: got v%b %0h expected v1 7", commit_valid, commit_val); end
    tick;
    n_checks++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL nobypass_popped: got %0d expected 0", rob_count); end
`endif
    commit_ready = 1'b0;
  endtask

  task automatic test_rdy_freeze;
    do_flush;
    push_one(5'd9, 32'h7000);
    set_wb(0, 4'd0, 32'h5A);
    tick;
    wb_valid = '0;
    rdy_in = 1'b0; commit_ready = 1'b1; push_valid = 1'b1;
    #1;
    n_checks++; if (push_ready !== 1'b0 || commit_valid !== 1'b1 || commit_val !== 32'h5A) begin n_fail++; $display("FAIL freeze_view: got rdy %b v%b %0h expected 0 1 5a", push_ready, commit_valid, commit_val); end
    tick; tick;
    n_checks++; if (rob_count !== 5'd1 || push_tag !== 4'd1) begin n_fail++; $display("FAIL freeze_hold: got cnt %0d tag %0d expected 1 1", rob_count, push_tag); end
    rdy_in = 1'b1; push_valid = 1'b0;
    tick;
    n_checks++; if (rob_count !== 5'd0) begin n_fail++; $display("FAIL freeze_release: got %0d expected 0", rob_count); end
    commit_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) push_one(5'(i), 32'h8000 + 32'(4 * i));
    set_wb(0, 4'd1, 32'h1); set_wb(1, 4'd2, 32'h2);
    tick;
    wb_valid = '0;
    rst_in = 1'b1;
    #1;
    n_checks++; if (rob_count !== 5'd0 || commit_valid !== 1'b0 || push_tag !== 4'd0) begin n_fail++; $display("FAIL midreset: got cnt %0d v%b tag %0d expected 0 0 0", rob_count, commit_valid, push_tag); end
    tick;
    rst_in = 1'b0; commit_ready = 1'b1;
    set_wb(0, 4'd1, 32'h3);
    tick;
    wb_valid = '0;
    tick;
    n_checks++; if (rob_count !== 5'd0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_after: got cnt %0d v%b expected 0 0", rob_count, commit_valid); end
    commit_ready = 1'b0;
  endtask

  task automatic test_random;
    ent_t          q[$];
    ent_t          e;
    logic [W-1:0]  next_tag;
    logic [D-1:0]  claimed;
    logic [XL-1:0] winv [D];
    logic [W-1:0]  t;
    logic          e_valid, pop, push;
    logic [XL-1:0] e_val;
    int            k;
    quiet;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    next_tag = '0;
    for (int c = 0; c < 3000; c++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      commit_ready = ($urandom_range(0, 9) < 7);
      push_valid   = ($urandom_range(0, 9) < 6);
      push_rd_idx  = 5'($urandom);
      push_pc      = $urandom;
      for (int p = 0; p < NW; p++) begin
        wb_valid[p] = ($urandom_range(0, 9) < 4);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, q.size() - 1);
          t = q[k].tag;
        end else begin
          t = W'($urandom);
        end
        wb_tag[p*W +: W]   = t;
        wb_val[p*XL +: XL] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) wb_tag[W +: W] = wb_tag[0 +: W];
      #1;
      claimed = '0;
      for (int p = 0; p < NW; p++) begin
        t = wb_tag[p*W +: W];
        if (wb_valid[p] && !claimed[t]) begin
          claimed[t] = 1'b1;
          winv[t]    = wb_val[p*XL +: XL];
        end
      end
      e_valid = 1'b0;
      e_val   = '0;
      if (q.size() > 0) begin
        if (q[0].done) begin
          e_valid = 1'b1; e_val = q[0].val;
        end else if (BYPASS && claimed[q[0].tag]) begin
          e_valid = 1'b1; e_val = winv[q[0].tag];
        end
      end
      n_checks++; if (rob_count !== (W+1)'(q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, rob_count, q.size()); end
      n_checks++; if (push_ready !== (rdy_in && q.size() < D)) begin n_fail++; $display("FAIL rnd_push_ready c%0d: got %b", c, push_ready); end
      n_checks++; if (push_tag !== next_tag) begin n_fail++; $display("FAIL rnd_push_tag c%0d: got %0d expected %0d", c, push_tag, next_tag); end
      n_checks++; if (commit_valid !== e_valid) begin n_fail++; $display("FAIL rnd_commit_valid c%0d: got %b expected %b", c, commit_valid, e_valid); end
      if (e_valid) begin
        n_checks++;
        if (commit_tag !== q[0].tag || commit_val !== e_val || commit_pc !== q[0].pc || commit_rd_idx !== q[0].rd) begin
          n_fail++;
          $display("FAIL rnd_commit_fields c%0d: got t%0d %0h pc %0h rd %0d expected t%0d %0h pc %0h rd %0d",
                   c, commit_tag, commit_val, commit_pc, commit_rd_idx, q[0].tag, e_val, q[0].pc, q[0].rd);
        end
      end
      if (rdy_in) begin
        if (flush) begin
          q.delete();
          next_tag = '0;
        end else begin
          pop  = e_valid && commit_ready;
          push = push_valid && (q.size() < D);
          for (int i = 0; i < q.size(); i++) begin
            if (claimed[q[i].tag] && !q[i].done) begin
              e = q[i]; e.done = 1'b1; e.val = winv[e.tag]; q[i] = e;
            end
          end
          if (pop) void'(q.pop_front());
          if (push) begin
            e.tag = next_tag; e.rd = push_rd_idx; e.pc = push_pc; e.done = 1'b0; e.val = '0;
            q.push_back(e);
            next_tag = next_tag + 1'b1;
          end
        end
      end
      tick;
    end
    quiet;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_full_pop_push;
    test_flush;
    test_in_order;
    test_same_tag;
    test_head_bypass;
    test_rdy_freeze;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_n.md
REORDER_BUFFER_N -- requirements
Module: reorder_buffer_n

Interface
REQ-001 SHALL have parameter ROB_DEPTH_W, default 4, log2 of entry count (16 entries); tag width TAG_W = ROB_DEPTH_W.
REQ-002 SHALL have parameter NUM_WB, default 2, number of writeback ports.
REQ-003 SHALL have parameter XLEN, default 32, value/PC width.
REQ-004 clk_in  input  1  sole clock, all state on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 rdy_in  input  1  global enable; low freezes all state.
REQ-007 push_valid  input  1  dispatch request.
REQ-008 push_rd_idx  input  5  destination register.
REQ-009 push_pc  input  XLEN  instruction address.
REQ-010 push_ready  output  1  entry available (count < depth and rdy_in).
REQ-011 push_tag  output  TAG_W  tag the current push receives (= tail pointer).
REQ-012 wb_valid  input  NUM_WB  per-port result strobe.
REQ-013 wb_tag  input  NUM_WB*TAG_W  per-port tag, port k at [k*TAG_W +: TAG_W].
REQ-014 wb_val  input  NUM_WB*XLEN  per-port result, same packing.
REQ-015 flush  input  1  misprediction clear.
REQ-016 commit_valid  output  1  head entry complete.
REQ-017 commit_ready  input  1  consumer accepts head.
REQ-018 commit_tag / commit_rd_idx / commit_val / commit_pc  output  TAG_W/5/XLEN/XLEN  head entry fields.
REQ-019 rob_count  output  ROB_DEPTH_W+1  occupied entries.

Function
REQ-020 Entry SHALL hold {busy, done, rd_idx, val, pc}; slot index is the tag.
REQ-021 Push SHALL occur when push_valid && push_ready: slot[tail] <= {1,0,rd,0,pc}, tail wraps depth-1 -> 0.
REQ-022 push_ready SHALL be 0 when rob_count == 2**ROB_DEPTH_W, even if a pop occurs the same cycle.
REQ-023 Writeback SHALL index the slot directly by wb_tag (no search) and set done, val only if slot busy && !done; otherwise ignored.
REQ-024 Two ports with same tag in one cycle: lowest port index SHALL win; others dropped.
REQ-025 commit_* outputs SHALL be combinational from head slot; commit_valid = count != 0 && head done.
REQ-026 Pop SHALL occur when commit_valid && commit_ready && rdy_in: head slot cleared, head wraps, one per cycle.
REQ-027 Simultaneous push and pop SHALL leave rob_count unchanged; push into slot being popped is impossible unless empty-after-wrap, and SHALL then store the new entry.
REQ-028 flush SHALL clear all busy/done bits, head, tail, count to 0 next edge, overriding push, writeback and pop that cycle.
REQ-029 rdy_in low SHALL hold all state; push_ready forced 0, no pop; commit_* still reflect head.
REQ-030 With empty ROB, commit_valid SHALL be 0 regardless of stale slot contents.

Reset
REQ-031 rst_in high SHALL asynchronously zero all slots, head, tail, rob_count.
REQ-032 During/after reset: commit_valid 0, push_tag 0, rob_count 0, commit_* fields 0, push_ready = rdy_in.
REQ-033 Reset mid-operation SHALL discard all in-flight entries; no commit issued for them.

Configuration
REQ-034 Macro ROB_HEAD_BYPASS_EN defined: a writeback (winning port) to the head tag while head busy && !done SHALL drive commit_valid=1 and commit_val=wb value in the same cycle, popping if commit_ready.
REQ-035 Macro undefined: head completion SHALL be visible on commit_valid one cycle after writeback; no combinational wb->commit path.

Structure
REQ-036 Entry field layout, default ROB_DEPTH_W, NUM_WB, XLEN SHALL live in the shared macros header, not in the module.
REQ-037 Port-priority/same-tag resolution SHALL be sub-module rob_wb_merge (NUM_WB ports in, per-slot write enable + value out).

Verification
REQ-038 Reset, push 16 entries (pc 0x1000+4i): push_tag 0..15, push_ready 0 after 16th, rob_count 16.
REQ-039 Writeback tag 1 val 0xAA then tag 0 val 0x55, commit_ready=1: commits tag0/0x55 then tag1/0xAA in order.
REQ-040 Ports 0 and 1 both tag 3 (0x11, 0x22) same cycle: commit_val for tag 3 = 0x11.
REQ-041 Full ROB, head done, commit_ready=1, push_valid=1: pop occurs, no push, count 15; next cycle push gets tag 0.
REQ-042 flush with 5 entries, 2 done: next cycle count 0, commit_valid 0, push_tag 0; late wb to old tag ignored.
REQ-043 Head tag 0 writeback 0x7 with commit_ready=1: commit same cycle if ROB_HEAD_BYPASS_EN, next cycle otherwise.
